// File: rtl/move_list_writer.sv
// move_list_writer: drains packed move words from the legal-move-generator FIFO
// into block RAM. Valid lanes of each word are compacted into consecutive RAM
// entries starting at BASE_ADDR+1; a count header goes to BASE_ADDR and a zero
// terminator follows the last move. Software polls the done level.
//
// Handshake: lmg_rden is a one-cycle pop strobe, high during the REQ cycle; the
// FIFO presents the popped word on lmg_word in the following (CAPTURE) cycle,
// where it is registered. There is no backpressure on the RAM side: a cycle
// with ram_wren=1 is one complete write of ram_data to ram_wraddr.
module move_list_writer #(
  parameter int LANES     = 8,
  parameter int MOVE_W    = 18,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 16,
  parameter int MAX_MOVES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          lmg_done,
  output logic                          lmg_rden,
  input  logic [LANES*(MOVE_W+1)-1:0]   lmg_word,
  output logic                          ram_wren,
  output logic [ADDR_W-1:0]             ram_wraddr,
  output logic [DATA_W-1:0]             ram_data,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [15:0]                   move_count,
  output logic [2:0]                    fsm_state
);

  localparam int LANE_W = MOVE_W + 1;
  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_LMG = 3'd1,
    S_REQ      = 3'd2,
    S_CAPTURE  = 3'd3,
    S_SCAN     = 3'd4,
    S_HEADER   = 3'd5,
    S_TERM     = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_W-1:0]    word_q;
  logic [LANES-1:0]     mask_q, mask_d;
  logic [15:0]          count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q;

  logic [LANES-1:0]     cap_mask;
  logic [LANES-1:0]     sel_onehot;
  logic [MOVE_W-1:0]    sel_move;
  logic [ADDR_W-1:0]    move_addr;
  logic [DATA_W-1:0]    hdr_data;

  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;

  // Pending mask of a freshly popped word: a lane is pending when its flag is 0.
  always_comb begin
    cap_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      cap_mask[i] = ~lmg_word[i*LANE_W + MOVE_W];
    end
  end

  // Priority pick of the lowest-index pending lane; scanning downwards lets
  // the lowest set bit overwrite any higher one.
  always_comb begin
    sel_onehot = '0;
    sel_move   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        sel_move      = word_q[i*LANE_W +: MOVE_W];
      end
    end
  end

  // Address of the next move slot (also where the terminator lands) and the
  // header word {overflow, zeros, count}.
  always_comb begin
    move_addr              = ADDR_W'(BASE_ADDR + 1) + ADDR_W'(count_q);
    hdr_data               = '0;
    hdr_data[DATA_W-1]     = ovf_q;
    hdr_data[15:0]         = count_q;
  end

  // Next-state, bookkeeping and write decision; abort overrides everything.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_addr = move_addr;
    wr_data = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_WAIT_LMG;
        end
      end
      S_WAIT_LMG: begin
        if (lmg_done) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        mask_d  = cap_mask;
        state_d = (cap_mask == '0) ? S_HEADER : S_SCAN;
      end
      S_SCAN: begin
        wr_en   = 1'b1;
        wr_addr = move_addr;
        wr_data = DATA_W'(sel_move);
        mask_d  = mask_q & ~sel_onehot;
        count_d = count_q + 16'd1;
        // Capacity reached: stop here, leaving remaining lanes and words unread.
        if (count_d == 16'(MAX_MOVES)) begin
          ovf_d   = 1'b1;
          state_d = S_HEADER;
        end else if (mask_d == '0) begin
          state_d = S_REQ;
        end
      end
      S_HEADER: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(BASE_ADDR);
        wr_data = hdr_data;
        state_d = S_TERM;
      end
      S_TERM: begin
        wr_en   = 1'b1;
        wr_addr = move_addr;
        wr_data = '0;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      wr_en   = 1'b0;
      mask_d  = mask_q;
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  // State, bookkeeping and registered outputs. The pop strobe is loaded on the
  // transition into REQ so it is high during REQ itself. done rises one cycle
  // after DONE is entered, i.e. after the terminator write has been presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      lmg_rden   <= 1'b0;
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_data   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      done_q   <= (state_q == S_DONE) && (state_d == S_DONE);
      lmg_rden <= (state_d == S_REQ);
      ram_wren <= wr_en;
      if (state_q == S_CAPTURE) word_q <= lmg_word;
      if (wr_en) begin
        ram_wraddr <= wr_addr;
        ram_data   <= wr_data;
      end
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign move_count = count_q;
  assign fsm_state  = state_q;

endmodule
